// File: rtl/pipe_reg_hs_if.sv
// Valid/ready handshake bundle for pipe_reg_hs: upstream input side plus downstream output side.
// master drives the input word and out_ready; slave is the register pipeline.
interface pipe_reg_hs_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_reg_hs.sv
// DEPTH-stage valid/ready register pipeline with collapsing bubbles, synchronous flush
// and a registered occupancy count.
module pipe_reg_hs #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          flush,
  pipe_reg_hs_if.slave  bus,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0]            r_v;
  logic [DEPTH-1:0][WIDTH-1:0] r_d;
  logic [CW-1:0]               r_count;
  logic [DEPTH-1:0]            w_rdy;
  logic [DEPTH-1:0]            w_src_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_d;
  logic                        w_in_xfer;
  logic                        w_out_xfer;

  // Unrolled ready chain: stage i may load if any stage from i to the output is empty,
  // or the output drains this cycle. Avoids a self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign w_rdy[i] = ~(&r_v[DEPTH-1:i]) | bus.out_ready;
  end

  assign w_src_v[0] = bus.in_valid;
  assign w_src_d[0] = bus.in_data;
  if (DEPTH > 1) begin : g_src
    assign w_src_v[DEPTH-1:1] = r_v[DEPTH-2:0];
    assign w_src_d[DEPTH-1:1] = r_d[DEPTH-2:0];
  end

  assign w_in_xfer  = bus.in_valid & w_rdy[0];
  assign w_out_xfer = r_v[DEPTH-1] & bus.out_ready;

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_d     <= '0;
      r_count <= '0;
    end else if (flush) begin
      // Data is left untouched so empty stages keep their last contents.
      r_v     <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
          if (w_src_v[i]) r_d[i] <= w_src_d[i];
        end
      end
      r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = r_d[DEPTH-1];
  assign count         = r_count;
endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs: DEPTH=3/WIDTH=8 instance for the main scenarios and a
// DEPTH=1/WIDTH=1 instance for the single-stage corner with a reference queue.
module tb_pipe_reg_hs;
  logic       ck = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       flush1;
  logic [1:0] count3;
  logic [0:0] count1;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 ck = ~ck;

  pipe_reg_hs_if #(.WIDTH(8)) b3();
  pipe_reg_hs_if #(.WIDTH(1)) b1();

  pipe_reg_hs #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .ck(ck), .rst_n(rst_n), .flush(flush), .bus(b3), .count(count3));
  pipe_reg_hs #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .ck(ck), .rst_n(rst_n), .flush(flush1), .bus(b1), .count(count1));

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    b3.in_valid = 1'b1; b3.in_data = 8'hAA; b3.out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%0b exp=0", b3.out_valid); end
    n_cmp++; if (b3.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got=%h exp=00", b3.out_data); end
    n_cmp++; if (count3 !== 2'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count3); end
    n_cmp++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%0b exp=1", b3.in_ready); end
    n_cmp++; if (count1 !== 1'd0) begin n_fail++; $display("FAIL rst_count1 got=%0d exp=0", count1); end
    rst_n = 1'b1; b3.in_valid = 1'b0;
    tick();
    n_cmp++; if (count3 !== 2'd0) begin n_fail++; $display("FAIL rel_count got=%0d exp=0", count3); end
    n_cmp++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid got=%0b exp=0", b3.out_valid); end
  endtask

  task automatic test_streaming();
    logic       ev;
    logic [1:0] ec;
    for (int t = 1; t <= 11; t++) begin
      b3.in_valid = (t <= 8); b3.in_data = 8'(t); b3.out_ready = 1'b1;
      tick();
      ev = (t >= 3 && t <= 10);
      ec = (t <= 3) ? 2'(t) : (t <= 8) ? 2'd3 : 2'(11 - t);
      n_cmp++; if (b3.out_valid !== ev) begin n_fail++; $display("FAIL stream_valid t=%0d got=%0b exp=%0b", t, b3.out_valid, ev); end
      n_cmp++; if (count3 !== ec) begin n_fail++; $display("FAIL stream_count t=%0d got=%0d exp=%0d", t, count3, ec); end
      if (ev) begin
        n_cmp++; if (b3.out_data !== 8'(t - 2)) begin n_fail++; $display("FAIL stream_data t=%0d got=%h exp=%h", t, b3.out_data, 8'(t - 2)); end
      end
    end
    b3.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] ed;
    b3.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b3.in_valid = 1'b1; b3.in_data = 8'h10 + 8'(k);
      tick();
    end
    b3.in_data = 8'h13;
    #1;
    n_cmp++; if (count3 !== 2'd3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", count3); end
    n_cmp++; if (b3.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%0b exp=0", b3.in_ready); end
    n_cmp++; if (b3.out_data !== 8'h10) begin n_fail++; $display("FAIL bp_hold got=%h exp=10", b3.out_data); end
    tick();
    n_cmp++; if (count3 !== 2'd3 || b3.out_data !== 8'h10 || b3.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_stall got=%0d/%h/%0b exp=3/10/1", count3, b3.out_data, b3.out_valid); end
    b3.out_ready = 1'b1;
    #1;
    n_cmp++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got=%0b exp=1", b3.in_ready); end
    tick();
    b3.in_valid = 1'b0;
    n_cmp++; if (b3.out_data !== 8'h11 || count3 !== 2'd3) begin
      n_fail++; $display("FAIL bp_drain0 got=%h/%0d exp=11/3", b3.out_data, count3); end
    for (int k = 1; k < 4; k++) begin
      tick();
      ed = 8'h11 + 8'(k);
      if (k < 3) begin
        n_cmp++; if (b3.out_valid !== 1'b1 || b3.out_data !== ed) begin
          n_fail++; $display("FAIL bp_drain k=%0d got=%0b/%h exp=1/%h", k, b3.out_valid, b3.out_data, ed); end
      end else begin
        n_cmp++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%0b exp=0", b3.out_valid); end
      end
      n_cmp++; if (count3 !== 2'(3 - k)) begin n_fail++; $display("FAIL bp_cnt k=%0d got=%0d exp=%0d", k, count3, 3 - k); end
    end
  endtask

  task automatic test_bubble();
    logic       ev;
    logic [7:0] ed;
    b3.out_ready = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      b3.in_valid = (t == 1 || t == 4); b3.in_data = (t == 1) ? 8'h55 : 8'h66;
      tick();
      ev = (t == 3 || t == 6);
      ed = (t == 3) ? 8'h55 : 8'h66;
      n_cmp++; if (b3.out_valid !== ev) begin n_fail++; $display("FAIL bub_valid t=%0d got=%0b exp=%0b", t, b3.out_valid, ev); end
      if (ev) begin
        n_cmp++; if (b3.out_data !== ed) begin n_fail++; $display("FAIL bub_data t=%0d got=%h exp=%h", t, b3.out_data, ed); end
      end
      n_cmp++; if (count3 !== ((t == 7) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL bub_count t=%0d got=%0d", t, count3); end
    end
    b3.out_ready = 1'b0; b3.in_valid = 1'b1; b3.in_data = 8'h5A;
    tick();
    b3.in_valid = 1'b0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready k=%0d got=%0b exp=1", k, b3.in_ready); end
      n_cmp++; if (b3.out_valid !== 1'b1 || b3.out_data !== 8'h5A || count3 !== 2'd1) begin
        n_fail++; $display("FAIL stall_hold k=%0d got=%0b/%h/%0d exp=1/5a/1", k, b3.out_valid, b3.out_data, count3); end
      tick();
    end
    b3.out_ready = 1'b1;
    tick();
    n_cmp++; if (b3.out_valid !== 1'b0 || count3 !== 2'd0) begin
      n_fail++; $display("FAIL stall_drain got=%0b/%0d exp=0/0", b3.out_valid, count3); end
  endtask

  task automatic test_flush();
    b3.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b3.in_valid = 1'b1; b3.in_data = 8'h21 + 8'(k);
      tick();
    end
    b3.in_data = 8'h77; b3.out_ready = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (b3.out_valid !== 1'b1 || b3.out_data !== 8'h21) begin
      n_fail++; $display("FAIL fl_oldest got=%0b/%h exp=1/21", b3.out_valid, b3.out_data); end
    tick();
    flush = 1'b0; b3.in_valid = 1'b0;
    n_cmp++; if (b3.out_valid !== 1'b0 || count3 !== 2'd0) begin
      n_fail++; $display("FAIL fl_clear got=%0b/%0d exp=0/0", b3.out_valid, count3); end
    n_cmp++; if (b3.out_data !== 8'h21) begin n_fail++; $display("FAIL fl_data_kept got=%h exp=21", b3.out_data); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (b3.out_valid !== 1'b0 || count3 !== 2'd0) begin
        n_fail++; $display("FAIL fl_no77 k=%0d got=%0b/%h/%0d exp=0/-/0", k, b3.out_valid, b3.out_data, count3); end
    end
  endtask

  task automatic test_midreset();
    b3.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b3.in_valid = 1'b1; b3.in_data = 8'h31 + 8'(k);
      tick();
    end
    b3.in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (b3.out_valid !== 1'b0 || b3.out_data !== 8'h00 || count3 !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst got=%0b/%h/%0d exp=0/00/0", b3.out_valid, b3.out_data, count3); end
    b3.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_empty k=%0d got=%0b exp=0", k, b3.out_valid); end
    end
  endtask

  task automatic test_depth1_full();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    b1.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b1.in_valid = 1'b1; b1.in_data = pat[k];
      #1;
      n_cmp++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_in_ready k=%0d got=%0b exp=1", k, b1.in_ready); end
      tick();
      n_cmp++; if (count1 !== 1'd1 || b1.out_valid !== 1'b1 || b1.out_data !== pat[k]) begin
        n_fail++; $display("FAIL d1_xfer k=%0d got=%0d/%0b/%0b exp=1/1/%0b", k, count1, b1.out_valid, b1.out_data, pat[k]); end
    end
    b1.in_valid = 1'b0;
    tick();
    n_cmp++; if (count1 !== 1'd0 || b1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL d1_drain got=%0d/%0b exp=0/0", count1, b1.out_valid); end
  endtask

  task automatic test_depth1_random();
    logic q[$];
    int   pushed;
    int   cyc;
    logic exp_rdy;
    pushed = 0; cyc = 0;
    while ((pushed < 100 || q.size() > 0) && cyc < 2000) begin
      b1.out_ready = (cyc % 2 == 1);
      b1.in_valid  = (pushed < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      b1.in_data   = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (q.size() == 0) || b1.out_ready;
      n_cmp++; if (b1.in_ready !== exp_rdy) begin n_fail++; $display("FAIL d1r_in_ready cyc=%0d got=%0b exp=%0b", cyc, b1.in_ready, exp_rdy); end
      n_cmp++; if (b1.out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL d1r_valid cyc=%0d got=%0b exp=%0b", cyc, b1.out_valid, q.size() > 0); end
      if (q.size() > 0 && b1.out_ready) begin
        n_cmp++; if (b1.out_data !== q[0]) begin n_fail++; $display("FAIL d1r_data cyc=%0d got=%0b exp=%0b", cyc, b1.out_data, q[0]); end
        void'(q.pop_front());
      end
      if (b1.in_valid && exp_rdy) begin
        q.push_back(b1.in_data);
        pushed++;
      end
      tick();
      n_cmp++; if (count1 !== 1'(q.size())) begin n_fail++; $display("FAIL d1r_count cyc=%0d got=%0d exp=%0d", cyc, count1, q.size()); end
      cyc++;
    end
    n_cmp++; if (cyc >= 2000) begin n_fail++; $display("FAIL d1r_timeout got=%0d pushed exp=100 drained", pushed); end
    b1.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush1 = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_midreset();
    test_depth1_full();
    test_depth1_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
